// File: rtl/myadder1_packet_summer.sv
// -----------------------------------------------------------------------------
// myadder1_packet_summer
//
// Reduces each tlast-delimited packet of 32-bit adder results into a single
// summary beat. The summary carries the 64-bit modular sum of every fully kept
// lane and, optionally, the packet's beat count.
//
// Optional feature macro: MYADDER1_SUMMER_BEATCNT_EN
//   defined   -> saturating 32-bit beat counter, placed in
//                m_axis_tdata[C_SUM_WIDTH+31:C_SUM_WIDTH]
//   undefined -> no counter logic, those bits are driven 0
//
// Handshake (both sides): a beat transfers on a rising edge where
// tvalid & tready are both 1. A master keeps tvalid and its payload stable
// until the transfer happens. tready may depend on internal state only.
//
// Ports
//   s_axis_aclk     in   sole clock, rising edge
//   s_axis_areset   in   asynchronous active-high reset
//   s_axis_tvalid   in   input beat valid
//   s_axis_tready   out  input ready (registered state only)
//   s_axis_tdata    in   C_AXIS_TDATA_WIDTH lanes of adder results
//   s_axis_tkeep    in   byte keep
//   s_axis_tlast    in   last beat of packet
//   m_axis_tvalid   out  summary beat valid
//   m_axis_tready   in   downstream ready
//   m_axis_tdata    out  {0, count, sum}
//   m_axis_tkeep    out  low (C_SUM_WIDTH+32)/8 bytes kept
//   m_axis_tlast    out  1 with every summary beat
//
// Pipeline for a packet whose last beat is accepted at edge N:
//   edge N   : masked lanes captured in stage 1
//   edge N+1 : lanes folded into the accumulator, summary marked pending
//   edge N+2 : summary loaded into the output register, accumulator cleared
// The input is held off from edge N until the summary handshake, so a new
// packet never shares the accumulator with a pending summary.
// -----------------------------------------------------------------------------
module myadder1_packet_summer #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_SUM_WIDTH        = 64
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast
);

  localparam int NUM_LANES = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
  localparam int LANE_KB   = C_ADDER_BIT_WIDTH / 8;
  localparam int KEEP_W    = C_AXIS_TDATA_WIDTH / 8;
  localparam int OUT_BYTES = (C_SUM_WIDTH + 32) / 8;

  localparam logic [KEEP_W-1:0] SUMMARY_KEEP =
    {{(KEEP_W - OUT_BYTES){1'b0}}, {OUT_BYTES{1'b1}}};

  // Stage 1
  logic                          s1_valid;
  logic                          s1_last;
  logic [C_AXIS_TDATA_WIDTH-1:0] s1_lanes;

  // Stage 2
  logic [C_SUM_WIDTH-1:0]        acc;
  logic                          sum_pending;

  logic                          s_accept;
  logic [C_AXIS_TDATA_WIDTH-1:0] masked_lanes;
  logic [C_SUM_WIDTH-1:0]        acc_next;
  logic [31:0]                   cnt_field;
  logic [C_AXIS_TDATA_WIDTH-1:0] summary_data;

  // Held low from the moment a last beat is accepted until its summary has
  // been handed off downstream.
  assign s_axis_tready = ~m_axis_tvalid & ~(s1_valid & s1_last) & ~sum_pending;
  assign s_accept      = s_axis_tvalid & s_axis_tready;

  // A lane counts only when every one of its keep bits is set; partially
  // kept lanes are dropped whole.
  always_comb begin
    masked_lanes = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (&s_axis_tkeep[i*LANE_KB +: LANE_KB]) begin
        masked_lanes[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] =
          s_axis_tdata[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH];
      end
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_lanes <= '0;
    end else begin
      s1_valid <= s_accept;
      if (s_accept) begin
        s1_lanes <= masked_lanes;
        s1_last  <= s_axis_tlast;
      end
    end
  end

  // Lanes zero-extended and summed with the running total; wraps naturally.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < NUM_LANES; i++) begin
      acc_next = acc_next +
        C_SUM_WIDTH'(s1_lanes[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH]);
    end
  end

  // sum_pending and s1_valid are never both set: input is blocked while a
  // summary is pending, so clearing takes priority without losing a beat.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      acc         <= '0;
      sum_pending <= 1'b0;
    end else begin
      sum_pending <= s1_valid & s1_last;
      if (sum_pending) begin
        acc <= '0;
      end else if (s1_valid) begin
        acc <= acc_next;
      end
    end
  end

`ifdef MYADDER1_SUMMER_BEATCNT_EN
  logic [31:0] beat_cnt;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      beat_cnt <= '0;
    end else if (sum_pending) begin
      beat_cnt <= '0;
    end else if (s1_valid && (beat_cnt != 32'hFFFF_FFFF)) begin
      beat_cnt <= beat_cnt + 32'd1;
    end
  end

  assign cnt_field = beat_cnt;
`else
  assign cnt_field = '0;
`endif

  always_comb begin
    summary_data = '0;
    summary_data[C_SUM_WIDTH-1:0]           = acc;
    summary_data[C_SUM_WIDTH+31:C_SUM_WIDTH] = cnt_field;
  end

  // Output register: loaded only while empty (input is blocked otherwise),
  // held stable under backpressure.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (sum_pending) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= summary_data;
      m_axis_tkeep  <= SUMMARY_KEEP;
      m_axis_tlast  <= 1'b1;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_myadder1_packet_summer.sv
module tb_myadder1_packet_summer;

  localparam int W  = 512;
  localparam int KW = W / 8;
`ifdef MYADDER1_SUMMER_BEATCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [W-1:0]  s_tdata  = '0;
  logic [KW-1:0] s_tkeep  = '0;
  logic          s_tlast  = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [W-1:0]  m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;

  myadder1_packet_summer dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] fill(input logic [31:0] v);
    logic [W-1:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = v;
    return d;
  endfunction

  function automatic logic [W-1:0] ramp(input logic [31:0] base);
    logic [W-1:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = base + 32'(i);
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send_beat(input logic [W-1:0] d, input logic [KW-1:0] k,
                           input logic l, output int waited);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    waited   = 0;
    while (!s_tready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("s_tready_timeout", 64'(s_tready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Called at the negedge right after a last-beat accept edge N.
  task automatic expect_summary(input string name);
    logic [63:0] exp_sum;
    logic [63:0] exp_cnt;
    int t;
    exp_sum = exp_q.pop_front();
    exp_cnt = exp_q.pop_front();
    check({name, "_tready_n0"}, 64'(s_tready), 64'd0);
    check({name, "_mvalid_n0"}, 64'(m_tvalid), 64'd0);
    @(negedge clk);
    check({name, "_mvalid_n1"}, 64'(m_tvalid), 64'd0);
    check({name, "_tready_n1"}, 64'(s_tready), 64'd0);
    @(negedge clk);
    check({name, "_mvalid_n2"}, 64'(m_tvalid), 64'd1);
    t = 0;
    while (!m_tvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({name, "_sum"},   m_tdata[63:0], exp_sum);
    check({name, "_cnt"},   64'(m_tdata[95:64]), CNT_EN ? exp_cnt : 64'd0);
    check({name, "_hi0"},   64'(|m_tdata[W-1:96]), 64'd0);
    check({name, "_tkeep"}, m_tkeep, 64'h0000_0000_0000_0FFF);
    check({name, "_tlast"}, 64'(m_tlast), 64'd1);
  endtask

  typedef struct {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    logic [63:0]   exp_sum;
    logic [63:0]   exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int waited;
    int bad_data, bad_rdy, bad_vld;
    bit first;
    logic [63:0] held;

    // 1-beat packet, lanes 1..16
    vecs[0] = '{ramp(32'd1), '1, 1'b1, 64'd136, 64'd1};
    // 4-beat packet, all ones
    vecs[1] = '{fill(32'hFFFF_FFFF), '1, 1'b0, 64'd0, 64'd0};
    vecs[2] = '{fill(32'hFFFF_FFFF), '1, 1'b0, 64'd0, 64'd0};
    vecs[3] = '{fill(32'hFFFF_FFFF), '1, 1'b0, 64'd0, 64'd0};
    vecs[4] = '{fill(32'hFFFF_FFFF), '1, 1'b1, 64'h0000_003F_FFFF_FFC0, 64'd4};
    // partial keep: lanes 1 and 4 only, then a partial lane 0, then no keep
    vecs[5] = '{fill(32'd5), 64'h0000_0000_000F_00F0, 1'b0, 64'd0, 64'd0};
    vecs[6] = '{fill(32'd5), 64'h0000_0000_0000_0007, 1'b0, 64'd0, 64'd0};
    vecs[7] = '{fill(32'd5), 64'h0, 1'b1, 64'd10, 64'd3};
    // even lanes kept, values 100..115 -> 100+102+...+114
    vecs[8] = '{ramp(32'd100), 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 64'd856, 64'd1};
    // single beat with one full lane 15
    vecs[9] = '{ramp(32'd0), 64'hF000_0000_0000_0000, 1'b1, 64'd15, 64'd1};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata",  64'(|m_tdata), 64'd0);
    check("rst_tkeep",  m_tkeep, 64'd0);
    check("rst_tlast",  64'(m_tlast), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tready", 64'(s_tready), 64'd1);

    // table-driven packets
    first = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_beat(vecs[i].data, vecs[i].keep, vecs[i].last, waited);
      if (!first) check($sformatf("v%0d_no_stall", i), 64'(waited), 64'd0);
      first = vecs[i].last;
      if (vecs[i].last) begin
        exp_q.push_back(vecs[i].exp_sum);
        exp_q.push_back(vecs[i].exp_cnt);
        expect_summary($sformatf("v%0d", i));
      end
    end

    // backpressure: summary held 20 cycles, next packet waits
    @(negedge clk);
    m_tready = 1'b0;
    send_beat(fill(32'd2), '1, 1'b1, waited);
    exp_q.push_back(64'd32);
    exp_q.push_back(64'd1);
    expect_summary("hold");
    held = m_tdata[63:0];
    bad_data = 0; bad_rdy = 0; bad_vld = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_tdata[63:0] !== 64'd32) bad_data++;
      if (s_tready !== 1'b0) bad_rdy++;
      if (m_tvalid !== 1'b1) bad_vld++;
    end
    check("hold_data_stable", 64'(bad_data), 64'd0);
    check("hold_tready_low",  64'(bad_rdy), 64'd0);
    check("hold_mvalid_high", 64'(bad_vld), 64'd0);
    check("hold_value",       held, 64'd32);
    // next packet presented while the summary is still pending
    s_tvalid = 1'b1; s_tdata = fill(32'd3); s_tkeep = '1; s_tlast = 1'b1;
    m_tready = 1'b1;
    check("hold_tready_pre_hs", 64'(s_tready), 64'd0);
    @(posedge clk);                      // summary handshake
    @(negedge clk);
    check("hold_mvalid_after_hs", 64'(m_tvalid), 64'd0);
    check("hold_tready_after_hs", 64'(s_tready), 64'd1);
    @(posedge clk);                      // first beat of next packet accepted
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    exp_q.push_back(64'd48);
    exp_q.push_back(64'd1);
    expect_summary("after_hold");

    // reset mid-packet discards the partial sum
    @(negedge clk);
    send_beat(fill(32'd7), '1, 1'b0, waited);
    send_beat(fill(32'd7), '1, 1'b0, waited);
    rst = 1'b1;
    #1;
    check("mid_rst_mvalid", 64'(m_tvalid), 64'd0);
    check("mid_rst_tdata",  64'(|m_tdata), 64'd0);
    check("mid_rst_tkeep",  m_tkeep, 64'd0);
    check("mid_rst_tlast",  64'(m_tlast), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tready", 64'(s_tready), 64'd1);
    send_beat(fill(32'd1), '1, 1'b1, waited);
    exp_q.push_back(64'd16);
    exp_q.push_back(64'd1);
    expect_summary("post_rst");
    repeat (3) @(negedge clk);
    check("final_mvalid_idle", 64'(m_tvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
